// File: rtl/bitwise_accumulator.sv
// Reduces a valid/ready burst of words with OR/AND/XOR (optionally inverted) into one registered result.
// Latency: result valid the cycle after the last beat; input stalls (in_ready=0) while a result is pending.
module bitwise_accumulator #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         op,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in0,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [COUNT_W-1:0] cnt;
  logic [2:0]         op_q;

  logic               accept;
  logic               first;
  logic [2:0]         cur_op;
  logic               invert;
  logic [WIDTH-1:0]   next_acc;
  logic [COUNT_W-1:0] next_cnt;
  logic [WIDTH-1:0]   result;

  // The first beat uses the live op code; later beats only see the latched copy.
  always_comb begin
    in_ready = (state != RESULT);
    accept   = in_valid && in_ready;
    first    = (state == IDLE);
    cur_op   = first ? op : op_q;
    case (cur_op)
      3'd2, 3'd3: next_acc = acc & in0;
      3'd4, 3'd5: next_acc = acc ^ in0;
      default:    next_acc = acc | in0;
    endcase
    if (first) next_acc = in0;
    invert   = (cur_op == 3'd1) || (cur_op == 3'd3) || (cur_op == 3'd5);
    next_cnt = first ? COUNT_W'(1) : ((&cnt) ? cnt : cnt + COUNT_W'(1));
    result   = invert ? ~next_acc : next_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= next_acc;
            cnt <= next_cnt;
            if (first) op_q <= op;
            if (in_last) begin
              state     <= RESULT;
              out_valid <= 1'b1;
              out       <= result;
              out_count <= next_cnt;
            end else begin
              state <= ACCUM;
            end
          end
        end
        RESULT: begin
          // Outputs read zero whenever no result is being offered.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            out_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bitwise_accumulator.md
# bitwise_accumulator

Parametrised, multi-mode successor to the two-input OR gate: reduces a burst of WIDTH-bit words with OR, NOR, AND, NAND, XOR or XNOR into a single registered result. Words arrive one per cycle over a valid/ready stream terminated by `in_last`; the result and beat count are presented on a valid/ready output port. It sits between word-producing datapath stages and consumers that need a flag or mask reduction, such as "any bit set" or "all bits set".

## Interface
- `WIDTH`, default 8: data word width, ≥1.
- `COUNT_W`, default 8: beat-counter width, ≥1.
- `clk` input 1: the block's single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input 3: operation code, sampled on the first beat of a burst only.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: block can accept a word.
- `in0` input WIDTH: input word.
- `in_last` input 1: this beat ends the burst.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out` output WIDTH: reduction result.
- `out_count` output COUNT_W: number of beats in the burst.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- The result is accepted when `out_valid && out_ready`.
- Op codes:
  - 0 = OR, 1 = NOR, 2 = AND, 3 = NAND, 4 = XOR, 5 = XNOR.
  - 6 and 7 behave as OR.
- Base operation per code:
  - OR for codes 0, 1, 6, 7.
  - AND for codes 2 and 3.
  - XOR for codes 4 and 5.
- The odd codes 1, 3 and 5 are inverting. Inversion is applied once, to the final result only, never per beat.
- The state machine has three states: IDLE, ACCUM, RESULT.
- **IDLE**
  - `in_ready`=1.
  - On the first accepted beat: `acc`←`in0`, `cnt`←1, and the op code is latched.
  - If `in_last`=1 on that beat, go to RESULT; otherwise go to ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - Each accepted beat: `acc`←`acc` BASEOP `in0`, and `cnt` increments.
  - `cnt` saturates at 2^COUNT_W−1 and does not wrap.
  - An accepted beat with `in_last`=1 goes to RESULT.
  - While `in_valid`=0, state and `acc` hold.
- **RESULT**
  - `in_ready`=0, `out_valid`=1.
  - `out` = `acc`, or ~`acc` if the latched op is inverting.
  - `out_count` = `cnt`.
  - `out` and `out_count` are stable while `out_valid`=1 and `out_ready`=0.
  - On output accept, go to IDLE.
- `op` changes during a burst are ignored.
- `in0` and `in_last` are ignored when the beat is not accepted.
- Reset (any state, including mid-burst or mid-result):
  - State goes to IDLE; `acc`, `cnt` and the latched op clear to 0.
  - Any partial burst is discarded and no result is emitted for it.

## Timing
- Reset values of the outputs:
  - `out_valid`=0, `out`=0, `out_count`=0.
  - `in_ready`=1, because it is decoded from state and the state is IDLE.
- `out` and `out_count` are driven from registers; `out`=0 and `out_count`=0 whenever `out_valid`=0.
- Input throughput is one beat per cycle in IDLE and ACCUM.
- Latency: `out_valid` rises on the cycle after the `in_last` beat is accepted.
- After output accept, `in_ready` returns to 1 on the next cycle. This gives exactly one idle cycle between the last input beat and the next burst's first beat, at minimum.
- `in_ready` depends only on state, never combinationally on `out_ready`.
- Reset takes effect immediately when `rst_n` falls. Release is synchronous to the next `clk` edge: the first beat can be accepted on the first rising edge with `rst_n`=1.

## Test plan
- **OR burst.** WIDTH=8, op=0, beats 0x01, 0x10, 0x80 with last on the third beat.
  - Required: `out`=0x91 and `out_count`=3 on the cycle after the third beat.
- **NAND single beat.** op=3, one beat 0xF0 with `in_last`=1.
  - Required: `out`=0x0F, `out_count`=1.
  - Repeat with op=2, beats 0xFF, 0x3C: `out`=0x3C, `out_count`=2.
- **XNOR with gaps and output backpressure.** op=5, beats 0xAA, 0x0F, 0xFF, with `in_valid` low for 2 cycles between beats, and `out_ready` held low for 4 cycles.
  - Required: `out`=0xA5 held stable with `out_valid`=1 until accepted.
  - Required: `in_ready`=0 throughout the RESULT state.
- **Op change mid-burst.** op=0 on beat 1 (0x01), op=2 on beat 2 (0x02, last).
  - Required: `out`=0x03 (the op latched on beat 1 is used).
- **Count saturation.** COUNT_W=2, 6-beat OR burst.
  - Required: `out_count`=3.
- **Reset mid-operation.**
  - Assert `rst_n`=0 after 2 beats of a burst: all outputs read their reset values immediately.
  - A new 1-beat burst of 0x55 with op=0 then yields `out`=0x55, `out_count`=1.
